// File: rtl/snn_core_load_sequencer_if.sv
// Signal bundle between the load sequencer, the read side of the parameter and
// instruction load FIFOs, the core's configuration write ports and the tick path.
interface snn_core_load_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int PARAM_W = 368,
  parameter int INST_W  = 2
);
  logic               start;

  logic               param_rempty;
  logic [PARAM_W-1:0] param_rdata;
  logic               param_rinc;

  logic               inst_rempty;
  logic [INST_W-1:0]  inst_rdata;
  logic               inst_rinc;

  logic               param_wen;
  logic [ADDR_W-1:0]  param_address;
  logic [PARAM_W-1:0] param_data_in;

  logic               neuron_inst_wen;
  logic [ADDR_W-1:0]  neuron_inst_address;
  logic [INST_W-1:0]  neuron_inst_data_in;

  logic               tick_in;
  logic               tick_out;
  logic               busy;
  logic               done;
  logic               tick_drop_error;

  modport master (
    input  start, param_rempty, param_rdata, inst_rempty, inst_rdata, tick_in,
    output param_rinc, inst_rinc,
           param_wen, param_address, param_data_in,
           neuron_inst_wen, neuron_inst_address, neuron_inst_data_in,
           tick_out, busy, done, tick_drop_error
  );

  modport slave (
    output start, param_rempty, param_rdata, inst_rempty, inst_rdata, tick_in,
    input  param_rinc, inst_rinc,
           param_wen, param_address, param_data_in,
           neuron_inst_wen, neuron_inst_address, neuron_inst_data_in,
           tick_out, busy, done, tick_drop_error
  );
endinterface

// File: rtl/snn_core_load_sequencer.sv
// Drains NUM_NEURONS parameter words then NUM_NEURONS instruction words into the
// core's configuration memories; ticks reach the core only once both are loaded.
module snn_core_load_sequencer #(
  parameter int NUM_NEURONS = 256,
  parameter int ADDR_W      = 8,
  parameter int PARAM_W     = 368,
  parameter int INST_W      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  snn_core_load_sequencer_if.master bus
);
  localparam int               CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(NUM_NEURONS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_PARAM,
    S_LOAD_INST,
    S_READY
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [CNT_W-1:0]   r_rd_cnt;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic               w_param_pop;
  logic               w_inst_pop;
  logic               w_write;

  logic               r_param_wen;
  logic [ADDR_W-1:0]  r_param_address;
  logic               r_inst_wen;
  logic [ADDR_W-1:0]  r_inst_address;
  logic               r_tick_out;
  logic               r_busy;
  logic               r_done;
  logic               r_tick_drop_error;

  assign w_write = r_param_wen | r_inst_wen;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A phase ends on the cycle its last write issues; pops lag nothing, writes lag pops by one.
  always_comb begin
    w_next_state = r_state;
    w_param_pop  = 1'b0;
    w_inst_pop   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next_state = S_LOAD_PARAM;
      end
      S_LOAD_PARAM: begin
        w_param_pop = ~bus.param_rempty & (r_rd_cnt < C_FULL);
        if (r_param_wen && (r_wr_cnt == C_LAST)) w_next_state = S_LOAD_INST;
      end
      S_LOAD_INST: begin
        w_inst_pop = ~bus.inst_rempty & (r_rd_cnt < C_FULL);
        if (r_inst_wen && (r_wr_cnt == C_LAST)) w_next_state = S_READY;
      end
      S_READY: begin
        if (bus.start) w_next_state = S_LOAD_PARAM;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_param_pop | w_inst_pop) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      if (w_write)                  r_wr_cnt <= r_wr_cnt + CNT_W'(1);
    end
  end

  // Writes are issued in pop order, so the write address is the read count at pop time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_param_wen       <= 1'b0;
      r_param_address   <= '0;
      r_inst_wen        <= 1'b0;
      r_inst_address    <= '0;
      r_tick_out        <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_tick_drop_error <= 1'b0;
    end else begin
      r_param_wen <= w_param_pop;
      if (w_param_pop) r_param_address <= r_rd_cnt[ADDR_W-1:0];
      r_inst_wen  <= w_inst_pop;
      if (w_inst_pop) r_inst_address <= r_rd_cnt[ADDR_W-1:0];
      r_tick_out  <= bus.tick_in & (r_state == S_READY);
      if (bus.tick_in && (r_state != S_READY)) r_tick_drop_error <= 1'b1;
      r_busy      <= (w_next_state == S_LOAD_PARAM) | (w_next_state == S_LOAD_INST);
      r_done      <= (w_next_state == S_READY);
    end
  end

  assign bus.param_rinc          = w_param_pop;
  assign bus.inst_rinc           = w_inst_pop;
  assign bus.param_wen           = r_param_wen;
  assign bus.param_address       = r_param_address;
  assign bus.neuron_inst_wen     = r_inst_wen;
  assign bus.neuron_inst_address = r_inst_address;
  // FIFO read data only lands in the write cycle, so it is passed through gated by the
  // registered enable; this keeps the data bus at zero outside writes and under reset.
  assign bus.param_data_in       = r_param_wen ? bus.param_rdata : '0;
  assign bus.neuron_inst_data_in = r_inst_wen  ? bus.inst_rdata  : '0;
  assign bus.tick_out            = r_tick_out;
  assign bus.busy                = r_busy;
  assign bus.done                = r_done;
  assign bus.tick_drop_error     = r_tick_drop_error;
endmodule

// File: tb/tb_snn_core_load_sequencer.sv
// Self-checking bench: FIFO models feed the sequencer while a phase/count reference
// model predicts every output cycle by cycle under random stalls, ticks and starts.
`timescale 1ns/1ps
module tb_snn_core_load_sequencer;
  localparam int N  = 256;
  localparam int AW = 8;
  localparam int PW = 368;
  localparam int IW = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  snn_core_load_sequencer_if #(.ADDR_W(AW), .PARAM_W(PW), .INST_W(IW)) bus ();

  snn_core_load_sequencer #(
    .NUM_NEURONS(N), .ADDR_W(AW), .PARAM_W(PW), .INST_W(IW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 parameters, 2 instructions, 3 ready
  int          m_phase = 0;
  int          m_pops  = 0;
  bit          m_err   = 1'b0;
  bit          e_pwen  = 1'b0;
  bit          e_iwen  = 1'b0;
  logic [AW-1:0] e_paddr = '0;
  logic [AW-1:0] e_iaddr = '0;
  logic [PW-1:0] e_pdata = '0;
  logic [IW-1:0] e_idata = '0;
  bit          e_tick  = 1'b0;
  bit          e_busy  = 1'b0;
  bit          e_done  = 1'b0;

  logic [PW-1:0] pq[$];
  logic [IW-1:0] iq[$];

  int cyc = 0;
  int load_cyc = 0;
  int done_cyc = -1;
  int obs_pw = 0;
  int obs_iw = 0;
  int ticks_seen = 0;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] rand_word();
    logic [PW-1:0] w;
    w = '0;
    for (int j = 0; j < 12; j++) w = {w[PW-33:0], 32'($urandom())};
    return w;
  endfunction

  task automatic refill(input bit seq);
    for (int k = 0; k < N; k++) begin
      pq.push_back(seq ? PW'(k) : rand_word());
      iq.push_back(seq ? IW'(k % 4) : IW'($urandom()));
    end
  endtask

  // One clock cycle: check registered outputs, apply inputs, check pops, advance model.
  task automatic step(input bit st, input bit tk, input bit ps, input bit is_);
    bit ep, ei, princ, irinc;
    int nphase, npops;
    chk("param_wen", bus.param_wen, e_pwen);
    chk("inst_wen", bus.neuron_inst_wen, e_iwen);
    if (e_pwen) begin
      chk("param_addr", bus.param_address, e_paddr);
      chk("param_data", bus.param_data_in, e_pdata);
    end
    if (e_iwen) begin
      chk("inst_addr", bus.neuron_inst_address, e_iaddr);
      chk("inst_data", bus.neuron_inst_data_in, e_idata);
    end
    chk("tick_out", bus.tick_out, e_tick);
    chk("busy", bus.busy, e_busy);
    chk("done", bus.done, e_done);
    chk("tick_drop_error", bus.tick_drop_error, m_err);
    if (bus.param_wen)       obs_pw++;
    if (bus.neuron_inst_wen) obs_iw++;
    if (bus.tick_out)        ticks_seen++;
    if (bus.done && done_cyc < 0 && cyc > load_cyc) done_cyc = cyc;

    bus.start        = st;
    bus.tick_in      = tk;
    bus.param_rempty = ps  || (pq.size() == 0);
    bus.inst_rempty  = is_ || (iq.size() == 0);
    #1;
    ep = (m_phase == 1) && !bus.param_rempty && (m_pops < N);
    ei = (m_phase == 2) && !bus.inst_rempty  && (m_pops < N);
    chk("param_rinc", bus.param_rinc, ep);
    chk("inst_rinc", bus.inst_rinc, ei);
    princ = bus.param_rinc;
    irinc = bus.inst_rinc;

    nphase = m_phase;
    npops  = m_pops + ((ep || ei) ? 1 : 0);
    if (m_phase == 1 && e_pwen && e_paddr == AW'(N - 1)) begin nphase = 2; npops = 0; end
    if (m_phase == 2 && e_iwen && e_iaddr == AW'(N - 1)) begin nphase = 3; npops = 0; end
    if (st && (m_phase == 0 || m_phase == 3)) begin nphase = 1; npops = 0; end
    if (tk && m_phase != 3) m_err = 1'b1;
    e_tick = tk && (m_phase == 3);
    e_pwen = ep;
    if (ep) begin e_paddr = AW'(m_pops); e_pdata = pq[0]; end
    e_iwen = ei;
    if (ei) begin e_iaddr = AW'(m_pops); e_idata = iq[0]; end
    m_phase = nphase;
    m_pops  = npops;
    e_busy  = (nphase == 1) || (nphase == 2);
    e_done  = (nphase == 3);

    @(posedge clk);
    #1;
    if (princ && pq.size() > 0) bus.param_rdata = pq.pop_front();
    if (irinc && iq.size() > 0) bus.inst_rdata  = iq.pop_front();
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_async();
    reset = 1'b1;
    bus.start   = 1'b0;
    bus.tick_in = 1'b0;
    #1;
    chk("rst_param_rinc", bus.param_rinc, 0);
    chk("rst_inst_rinc", bus.inst_rinc, 0);
    chk("rst_param_wen", bus.param_wen, 0);
    chk("rst_inst_wen", bus.neuron_inst_wen, 0);
    chk("rst_param_addr", bus.param_address, 0);
    chk("rst_inst_addr", bus.neuron_inst_address, 0);
    chk("rst_param_data", bus.param_data_in, 0);
    chk("rst_inst_data", bus.neuron_inst_data_in, 0);
    chk("rst_tick_out", bus.tick_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tick_drop_error", bus.tick_drop_error, 0);
    m_phase = 0; m_pops = 0; m_err = 1'b0;
    e_pwen = 1'b0; e_iwen = 1'b0; e_paddr = '0; e_iaddr = '0;
    e_pdata = '0; e_idata = '0; e_tick = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_load(input int stall_pct, input bit rand_tick, input bit rand_start,
                          input int stall_at, input bit seq, input bit start_tick,
                          output int lat);
    int  budget;
    int  stall_left;
    bit  ps, is_, tk, st, forced;
    refill(seq);
    obs_pw = 0; obs_iw = 0; done_cyc = -1; stall_left = 10; forced = 1'b0;
    load_cyc = cyc;
    step(1'b1, start_tick, 1'b0, 1'b0);
    budget = 0;
    while (!(m_phase == 3 && e_done) && budget < 3000) begin
      ps  = ($urandom_range(99) < stall_pct);
      is_ = ($urandom_range(99) < stall_pct);
      if (stall_at >= 0 && m_phase == 1 && m_pops == stall_at && stall_left > 0) begin
        ps = 1'b1;
        stall_left--;
      end
      tk = rand_tick && ($urandom_range(7) == 0);
      if (rand_tick && !forced && m_phase == 2 && m_pops == 10) begin
        tk = 1'b1;
        forced = 1'b1;
      end
      st = rand_start && ($urandom_range(31) == 0);
      step(st, tk, ps, is_);
      budget++;
    end
    chk("load_in_budget", budget < 3000, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("param_write_count", obs_pw, N);
    chk("inst_write_count", obs_iw, N);
    lat = (done_cyc < 0) ? -1 : done_cyc - load_cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int t0;
    int b;
    bus.start = 1'b0; bus.tick_in = 1'b0;
    bus.param_rempty = 1'b1; bus.inst_rempty = 1'b1;
    bus.param_rdata = '0; bus.inst_rdata = '0;
    @(negedge clk);
    reset_async();
    $display("reset: outputs checked");

    run_load(0, 1'b0, 1'b0, -1, 1'b1, 1'b0, lat);
    chk("latency_clean", lat, 515);
    $display("load clean sequential data: done after %0d cycles", lat);

    run_load(0, 1'b0, 1'b0, 100, 1'b0, 1'b0, lat);
    chk("latency_stall10", lat, 525);
    $display("load with 10-cycle stall after pop 100: done after %0d cycles", lat);

    run_load(25, 1'b1, 1'b1, -1, 1'b0, 1'b0, lat);
    chk("drop_err_sticky", bus.tick_drop_error, 1);
    $display("load random stalls/ticks/starts: done after %0d cycles", lat);

    t0 = ticks_seen;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ready_tick_count", ticks_seen - t0, 3);
    $display("ready: %0d ticks forwarded", ticks_seen - t0);

    run_load(0, 1'b0, 1'b0, -1, 1'b0, 1'b1, lat);
    chk("latency_reload", lat, 515);
    $display("reload from ready with coincident tick: done after %0d cycles", lat);

    refill(1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    b = 0;
    while (!(e_pwen && e_paddr == AW'(128)) && b < 1000) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      b++;
    end
    chk("reached_write_128", b < 1000, 1);
    reset_async();
    $display("reset during parameter write 128");

    run_load(10, 1'b0, 1'b0, -1, 1'b0, 1'b0, lat);
    chk("restart_done_seen", lat > 0, 1);
    $display("fresh load after reset: done after %0d cycles", lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
